// File: rtl/prog_mem_sync.sv
// Synchronous single-clock program memory with a FILL initialisation sweep, range-checked
// read/write ports and optional output register stage (macro PROG_MEM_OUTREG_EN).
module prog_mem_sync #(
    parameter int unsigned       DATA_W = 8,
    parameter int unsigned       ADDR_W = 8,
    parameter int unsigned       DEPTH  = 128,
    parameter int unsigned       BASE   = 0,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              rd_err,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_address,
    input  logic [DATA_W-1:0] data_in,
    output logic              wr_err,
    output logic              busy
);

    localparam int unsigned       CntW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   BaseExt  = (ADDR_W + 1)'(BASE);
    localparam logic [ADDR_W:0]   EndExt   = (ADDR_W + 1)'(BASE + DEPTH);
    localparam logic [ADDR_W-1:0] AddrBase = ADDR_W'(BASE);
    localparam logic [CntW-1:0]   LastIdx  = CntW'(DEPTH - 1);

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] mem [DEPTH];

    logic            rd_mapped, wr_mapped, rd_accept, wr_accept;
    logic [CntW-1:0] rd_idx, wr_idx;

    // Range checks use ADDR_W+1 bits so BASE+DEPTH == 2^ADDR_W does not wrap.
    always_comb begin
        rd_mapped = ({1'b0, address} >= BaseExt) && ({1'b0, address} < EndExt);
        wr_mapped = ({1'b0, wr_address} >= BaseExt) && ({1'b0, wr_address} < EndExt);
        rd_idx    = CntW'(address - AddrBase);
        wr_idx    = CntW'(wr_address - AddrBase);
        rd_accept = (state_q == StReady) && rd_en;
        wr_accept = (state_q == StReady) && wr_en;
        busy      = (state_q == StInit);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == LastIdx) begin
                    state_d = StReady;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StReady: begin
                state_d = StReady;
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is not reset; the sweep provides the defined contents.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == StInit) begin
                mem[cnt_q] <= FILL;
            end else if (wr_accept && wr_mapped) begin
                mem[wr_idx] <= data_in;
            end
        end
    end

    logic              rd_valid_q, rd_err_q, wr_err_q;
    logic [DATA_W-1:0] rd_data_q;

    // Nonblocking read against the same-edge write gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= rd_accept;
            rd_err_q   <= rd_accept && !rd_mapped;
            wr_err_q   <= wr_accept && !wr_mapped;
            if (rd_accept) begin
                rd_data_q <= rd_mapped ? mem[rd_idx] : '0;
            end
        end
    end

    assign wr_err = wr_err_q;

`ifdef PROG_MEM_OUTREG_EN
    logic              out_valid_q, out_err_q;
    logic [DATA_W-1:0] out_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= rd_valid_q;
            out_err_q   <= rd_valid_q && rd_err_q;
            if (rd_valid_q) begin
                out_data_q <= rd_data_q;
            end
        end
    end

    assign rd_valid = out_valid_q;
    assign rd_err   = out_err_q;
    assign data_out = out_data_q;
`else
    assign rd_valid = rd_valid_q;
    assign rd_err   = rd_err_q;
    assign data_out = rd_data_q;
`endif

endmodule

// File: tb/tb_prog_mem_sync.sv
// Self-checking bench for prog_mem_sync (BASE=0x80, DEPTH=128, FILL=0); honours
// PROG_MEM_OUTREG_EN to select the expected read latency.
module tb_prog_mem_sync;

`ifdef PROG_MEM_OUTREG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    logic       clk, reset, rd_en, wr_en;
    logic [7:0] address, wr_address, data_in, data_out;
    logic       rd_valid, rd_err, wr_err, busy;

    int n_pass  = 0;
    int n_total = 0;

    prog_mem_sync #(
        .DATA_W(8),
        .ADDR_W(8),
        .DEPTH (128),
        .BASE  (8'h80),
        .FILL  (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_en     (rd_en),
        .address   (address),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .rd_err    (rd_err),
        .wr_en     (wr_en),
        .wr_address(wr_address),
        .data_in   (data_in),
        .wr_err    (wr_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (act timeout, req finish)");
        $fatal(1);
    end

    typedef struct {
        logic       rd;
        logic [7:0] ra;
        logic       wr;
        logic [7:0] wa;
        logic [7:0] wd;
        logic       exp_rv;
        logic [7:0] exp_data;
        logic       exp_rerr;
        logic       exp_werr;
    } vec_t;

    vec_t vecs [13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %0h required %0h", name, act, exp);
    endtask

    task automatic idle();
        rd_en = 1'b0; wr_en = 1'b0; address = '0; wr_address = '0; data_in = '0;
    endtask

    // Count cycles until busy drops; any rd_valid/wr_err meanwhile is an error.
    task automatic sweep(input string name);
        int n = 0;
        int bad = 0;
        while (busy && n < 300) begin
            step();
            n++;
            if (rd_valid || wr_err) bad++;
        end
        idle();
        check({name, "_busy_cycles"}, n, 128);
        check({name, "_no_pulse_in_init"}, bad, 0);
    endtask

    initial begin
        vecs[0]  = '{1'b0, 8'h00, 1'b1, 8'hE0, 8'hAA, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 8'hE0, 1'b0, 8'h00, 8'h00, 1'b1, 8'hAA, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 8'h80, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h7F, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'h10, 8'h55, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 8'h90, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 8'h85, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 8'h85, 1'b1, 8'h85, 8'h22, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h85, 1'b0, 8'h00, 8'h00, 1'b1, 8'h22, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 8'hE0, 1'b1, 8'hFF, 8'h5A, 1'b1, 8'hAA, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0};

        // Reset with both requests active: reset must win.
        reset = 1'b1; rd_en = 1'b1; address = 8'h80; wr_en = 1'b1; wr_address = 8'h10;
        data_in = 8'hFF;
        step();
        check("rst_busy", busy, 1);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_err", rd_err, 0);
        check("rst_wr_err", wr_err, 0);
        check("rst_data_out", data_out, 0);

        // Requests kept high during the sweep must be ignored.
        reset = 1'b0;
        sweep("init");
        repeat (L) step();
        check("post_init_rd_valid", rd_valid, 0);

        foreach (vecs[k]) begin
            rd_en = vecs[k].rd; address = vecs[k].ra;
            wr_en = vecs[k].wr; wr_address = vecs[k].wa; data_in = vecs[k].wd;
            step();
            idle();
            check($sformatf("v%0d_wr_err", k), wr_err, vecs[k].exp_werr);
            repeat (L - 1) step();
            check($sformatf("v%0d_rd_valid", k), rd_valid, vecs[k].exp_rv);
            check($sformatf("v%0d_rd_err", k), rd_err, vecs[k].exp_rerr);
            if (vecs[k].exp_rv) check($sformatf("v%0d_data", k), data_out, vecs[k].exp_data);
        end
        step();
        check("wr_err_one_cycle", wr_err, 0);

        // Preload 0x80..0x8F with 0x30+i, then stream reads back to back.
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_address = 8'h80 + 8'(i); data_in = 8'h30 + 8'(i);
            step();
        end
        idle();
        for (int i = 0; i < 16 + L - 1; i++) begin
            if (i < 16) begin
                rd_en = 1'b1; address = 8'h80 + 8'(i);
            end else begin
                rd_en = 1'b0;
            end
            step();
            if (i >= L - 1) begin
                check($sformatf("stream%0d_valid", i - L + 1), rd_valid, 1);
                check($sformatf("stream%0d_data", i - L + 1), data_out, 8'h30 + 8'(i - L + 1));
            end
        end
        idle();
        step();
        check("stream_end_valid", rd_valid, 0);

        // Reset mid-stream: in-flight reads are dropped and the sweep restarts.
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1; address = 8'h80 + 8'(i);
            step();
        end
        reset = 1'b1;
        step();
        check("midrst_rd_valid", rd_valid, 0);
        check("midrst_busy", busy, 1);
        check("midrst_data_out", data_out, 0);
        reset = 1'b0;
        idle();
        sweep("resweep");
        rd_en = 1'b1; address = 8'h85;
        step();
        idle();
        repeat (L - 1) step();
        check("resweep_rd_valid", rd_valid, 1);
        check("resweep_data", data_out, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/prog_mem_sync.md
PROG_MEM_SYNC -- requirements
Module: prog_mem_sync

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width in bits.
REQ-003 Parameter DEPTH, default 128, number of words; SHALL satisfy 1 <= DEPTH <= 2^ADDR_W.
REQ-004 Parameter BASE, default 0, first mapped address; SHALL satisfy BASE+DEPTH <= 2^ADDR_W.
REQ-005 Parameter FILL, default 0, DATA_W-bit value written to every word during initialisation.
REQ-006 One clock; reset is synchronous and active-high.
REQ-007 clk  in  1  clock; all state changes on its rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 rd_en  in  1  read request, sampled each rising edge.
REQ-010 address  in  ADDR_W  read address.
REQ-011 data_out  out  DATA_W  read data.
REQ-012 rd_valid  out  1  one-cycle pulse; data_out/rd_err belong to a completed read.
REQ-013 rd_err  out  1  qualifies rd_valid; read address was unmapped.
REQ-014 wr_en  in  1  write request, sampled each rising edge.
REQ-015 wr_address  in  ADDR_W  write address.
REQ-016 data_in  in  DATA_W  write data.
REQ-017 wr_err  out  1  one-cycle pulse; accepted write targeted an unmapped address.
REQ-018 busy  out  1  high while initialisation runs; requests are ignored.

Function
REQ-019 Mapped: BASE <= addr < BASE+DEPTH; word index = addr-BASE; arithmetic is unsigned ADDR_W+1 bits, so BASE+DEPTH never wraps.
REQ-020 FSM has two states: INIT (busy=1) and READY (busy=0).
REQ-021 INIT writes FILL to index 0..DEPTH-1, one word per cycle in ascending order; after writing index DEPTH-1 the FSM enters READY on the same edge; INIT lasts exactly DEPTH cycles.
REQ-022 In INIT, rd_en and wr_en are ignored: no memory write, rd_valid, rd_err or wr_err pulse.
REQ-023 In READY, rd_en=1 at edge N: rd_valid=1 after edge N+L-1 for one cycle, L = read latency (REQ-033/034); one read accepted per cycle, back-to-back reads give consecutive rd_valid pulses.
REQ-024 Mapped read: data_out = stored word, rd_err=0; unmapped read: data_out = 0, rd_err=1.
REQ-025 When rd_valid=0, data_out holds its last value and rd_err=0.
REQ-026 In READY, wr_en=1 with mapped wr_address writes data_in at that edge; unmapped: no write, wr_err=1 for the following cycle.
REQ-027 Simultaneous read and write of the same mapped word: read returns the old word (read-first); the new word is visible to reads accepted from the next edge on.
REQ-028 Read and write ports are independent; both may be active every cycle.

Reset
REQ-029 reset=1 at an edge: FSM -> INIT, init counter -> 0, data_out -> 0, rd_valid/rd_err/wr_err -> 0, busy -> 1, all pipeline stages cleared.
REQ-030 reset overrides every other input, including rd_en/wr_en on the same edge.
REQ-031 reset during INIT restarts the sweep from index 0; reset during READY discards in-flight reads (no rd_valid emitted for them).
REQ-032 First full INIT sweep starts on the first edge after reset deasserts.

Configuration
REQ-033 Macro PROG_MEM_OUTREG_EN defined: one extra output register stage; L=2; data_out, rd_valid, rd_err delayed together; throughput unchanged.
REQ-034 PROG_MEM_OUTREG_EN undefined: L=1; no extra stage; wr_err timing identical in both builds.

Verification
REQ-035 Reset 1 cycle, DEPTH=128, FILL=8'h00 -> busy high for exactly 128 cycles after reset release; reads during busy yield no rd_valid; afterwards read 0x00, 0x7F -> data_out 8'h00, rd_err 0.
REQ-036 Write 8'hAA to 0xE0 with BASE=0x80 then read 0xE0 -> rd_valid after L cycles, data_out 8'hAA, rd_err 0.
REQ-037 BASE=0x80: read 0x7F and 0x00 -> rd_valid=1, rd_err=1, data_out 8'h00; write 0x10 -> wr_err pulse 1 cycle, memory unchanged.
REQ-038 Word 0x85 holds 8'h11; same edge write 8'h22 to 0x85 and read 0x85 -> 8'h11; next-cycle read -> 8'h22.
REQ-039 Reads streamed every cycle over 0x80..0x8F -> 16 consecutive rd_valid pulses, data in order; assert reset mid-stream -> no further rd_valid, busy=1, sweep restarts at index 0.
REQ-040 Run REQ-036 and REQ-039 with and without PROG_MEM_OUTREG_EN -> L=2 and L=1 respectively, identical data sequences.
